// File: rtl/pipelined_cache_ctrl.sv
// Sequencing controller for a two-stage pipelined 2-way cache: hit service, dirty-victim
// writeback, line allocate and re-lookup, plus saturating hit/miss/writeback counters.
module pipelined_cache_ctrl #(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid_s2,
   input  logic                 req_write_s2,
   input  logic                 hit_s2,
   input  logic                 hit_way_s2,
   input  logic                 lru_s2,
   input  logic                 dirty_s2,
   input  logic                 pmem_resp,
   input  logic                 clear_counters,
   output logic                 pipe_load,
   output logic                 relookup,
   output logic                 cpu_resp,
   output logic                 cpu_stall,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic                 pmem_addr_sel,
   output logic                 data_we,
   output logic                 data_sel,
   output logic                 way_sel,
   output logic                 tag_we,
   output logic                 dirty_we,
   output logic                 dirty_val,
   output logic                 lru_we,
   output logic                 lru_val,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count,
   output logic [CNT_WIDTH-1:0] wb_count
);

   typedef enum logic [1:0] {
      RUN,
      WRITEBACK,
      ALLOCATE,
      REFILL
   } state_t;

   state_t state;
   state_t state_next;

   logic hit_ev;
   logic miss_ev;
   logic wb_ev;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   always_comb begin
      state_next    = state;
      pipe_load     = 1'b0;
      relookup      = 1'b0;
      cpu_resp      = 1'b0;
      cpu_stall     = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      data_we       = 1'b0;
      data_sel      = 1'b0;
      way_sel       = 1'b0;
      tag_we        = 1'b0;
      dirty_we      = 1'b0;
      dirty_val     = 1'b0;
      lru_we        = 1'b0;
      lru_val       = 1'b0;
      hit_ev        = 1'b0;
      miss_ev       = 1'b0;
      wb_ev         = 1'b0;

      unique case (state)
         RUN: begin
            if (!req_valid_s2) begin
               pipe_load = 1'b1;
            end else if (hit_s2) begin
               cpu_resp  = 1'b1;
               pipe_load = 1'b1;
               lru_we    = 1'b1;
               lru_val   = ~hit_way_s2;
               way_sel   = hit_way_s2;
               hit_ev    = 1'b1;
               if (req_write_s2) begin
                  data_we   = 1'b1;
                  dirty_we  = 1'b1;
                  dirty_val = 1'b1;
               end
            end else begin
               cpu_stall  = 1'b1;
               miss_ev    = 1'b1;
               state_next = dirty_s2 ? WRITEBACK : ALLOCATE;
            end
         end

         WRITEBACK: begin
            cpu_stall     = 1'b1;
            pmem_write    = 1'b1;
            pmem_addr_sel = 1'b1;
            way_sel       = lru_s2;
            if (pmem_resp) begin
               wb_ev      = 1'b1;
               state_next = ALLOCATE;
            end
         end

         ALLOCATE: begin
            cpu_stall = 1'b1;
            pmem_read = 1'b1;
            // Fill is written in the same cycle the line arrives; no buffering register.
            if (pmem_resp) begin
               data_we    = 1'b1;
               data_sel   = 1'b1;
               way_sel    = lru_s2;
               tag_we     = 1'b1;
               dirty_we   = 1'b1;
               dirty_val  = 1'b0;
               state_next = REFILL;
            end
         end

         REFILL: begin
            cpu_stall  = 1'b1;
            relookup   = 1'b1;
            state_next = RUN;
         end

         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Counters saturate at all-ones; clear takes priority over a same-cycle event.
   always_ff @(posedge clk) begin
      if (rst || clear_counters) begin
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         if (hit_ev && hit_count != '1) begin
            hit_count <= hit_count + CNT_ONE;
         end
         if (miss_ev && miss_count != '1) begin
            miss_count <= miss_count + CNT_ONE;
         end
         if (wb_ev && wb_count != '1) begin
            wb_count <= wb_count + CNT_ONE;
         end
      end
   end

endmodule
